// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output path: complex sample type and
// index bit reversal used to undo radix-2 butterfly ordering.
package fft_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 15;
    localparam int MAX_LOG2   = 10;

    typedef logic signed [1:0][DATA_WIDTH-1:0] cplx_t;

    // Reverses the low nbits of idx; bits above nbits come back as zero.
    function automatic logic [MAX_LOG2-1:0] bitrev(
        input logic [MAX_LOG2-1:0] idx,
        input int                  nbits
    );
        logic [MAX_LOG2-1:0] src;
        logic [MAX_LOG2-1:0] res;
        src = idx;
        res = '0;
        for (int i = 0; i < MAX_LOG2; i++) begin
            if (i < nbits) begin
                res = {res[MAX_LOG2-2:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_pingpong_ctrl.sv
// Ping-pong bank controller for the bit-reversal buffer: write/read counters,
// bank selects, per-bank full flags and the ready/valid/last handshakes.
//
// bank state | meaning
// FILLING    | full=0, wr_sel points at it, accepting samples
// FULL       | full=1, waiting for the reader
// DRAINING   | full=1 and rd_sel points at it, samples being emitted
// EMPTY      | full=0 after the last read, free for the next write
module fft_pingpong_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2 = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [N_LOG2-1:0] wr_addr_o,
    output logic              rd_bank_o,
    output logic [N_LOG2-1:0] rd_addr_o
);

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [1:0]        full_q, full_d;
    logic              wr_fire;
    logic              rd_fire;

    // Ready and valid come straight from registered flags, so a bank freed by
    // the last read is only writable one cycle later.
    always_comb begin
        in_ready_o  = ~full_q[wr_sel_q];
        out_valid_o = full_q[rd_sel_q];
        out_last_o  = out_valid_o & (rd_cnt_q == CNT_LAST);
        wr_fire     = in_valid_i & in_ready_o;
        rd_fire     = out_valid_o & out_ready_i;

        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == CNT_LAST) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end

        // The reader only ever touches a full bank and the writer an empty
        // one, so both flag updates can land in the same cycle.
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == CNT_LAST) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= 2'b00;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
        end
    end

    assign wr_en_o   = wr_fire;
    assign wr_bank_o = wr_sel_q;
    assign wr_addr_o = N_LOG2'(bitrev(MAX_LOG2'(wr_cnt_q), N_LOG2));
    assign rd_bank_o = rd_sel_q;
    assign rd_addr_o = rd_cnt_q;

endmodule

// File: rtl/fft_bitrev_buf.sv
// Two-bank reorder buffer behind the last radix-2 stage: writes arrive in
// bit-reversed order and frames drain in natural order with a last marker.
module fft_bitrev_buf #(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int N_LOG2     = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic signed [1:0][DATA_WIDTH-1:0]  in_data_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    output logic signed [1:0][DATA_WIDTH-1:0]  out_data_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic                               out_last_o
);
    import fft_pkg::*;

    localparam int N = 1 << N_LOG2;

    logic                              wr_en;
    logic                              wr_bank;
    logic [N_LOG2-1:0]                 wr_addr;
    logic                              rd_bank;
    logic [N_LOG2-1:0]                 rd_addr;
    logic signed [1:0][DATA_WIDTH-1:0] mem_q [2][N];

    fft_pingpong_ctrl #(
        .N_LOG2(N_LOG2)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o (out_last_o),
        .wr_en_o    (wr_en),
        .wr_bank_o  (wr_bank),
        .wr_addr_o  (wr_addr),
        .rd_bank_o  (rd_bank),
        .rd_addr_o  (rd_addr)
    );

    // Sample storage is never reset; a bank is only read after a full frame
    // has been written into it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_addr] <= in_data_i;
        end
    end

    assign out_data_o = mem_q[rd_bank][rd_addr];

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Self-checking bench for fft_bitrev_buf: vector table, scoreboard and
// multi-cycle corner sequences.
module tb_fft_bitrev_buf;

    localparam int NL = 3;
    localparam int N  = 8;

    logic clk;
    logic rst;

    logic signed [1:0][15:0] in_data, out_data;
    logic in_valid, in_ready, out_valid, out_ready, out_last;

    logic signed [1:0][15:0] a_in, a_out;
    logic a_iv, a_ir, a_ov, a_or, a_ol;
    logic signed [1:0][15:0] b_in, b_out;
    logic b_iv, b_ir, b_ov, b_or, b_ol;

    fft_bitrev_buf #(.DATA_WIDTH(16), .N_LOG2(NL)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last)
    );

    fft_bitrev_buf #(.DATA_WIDTH(16), .N_LOG2(1)) dut_n1 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(a_in), .in_valid_i(a_iv), .in_ready_o(a_ir),
        .out_data_o(a_out), .out_valid_o(a_ov), .out_ready_i(a_or),
        .out_last_o(a_ol)
    );

    fft_bitrev_buf #(.DATA_WIDTH(16), .N_LOG2(4)) dut_n4 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(b_in), .in_valid_i(b_iv), .in_ready_o(b_ir),
        .out_data_o(b_out), .out_valid_o(b_ov), .out_ready_i(b_or),
        .out_last_o(b_ol)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_bitrev(input int v, input int nb);
        int r;
        r = 0;
        for (int i = 0; i < nb; i++)
            if ((v & (1 << i)) != 0) r = r | (1 << (nb - 1 - i));
        return r;
    endfunction

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fb_re [N];
    logic [15:0] fb_im [N];
    int          fb_n;
    int          out_seen;

    logic        s_ir, s_ov, s_ol;
    logic [15:0] s_re, s_im;

    // One clock: drive at the falling edge, sample just after, and account
    // for the transfers that the next rising edge will perform.
    task automatic cycle(input logic v, input logic [15:0] re, input logic [15:0] im,
                         input logic rdy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid   = v;
        in_data[0] = re;
        in_data[1] = im;
        out_ready  = rdy;
        #1;
        s_ir = in_ready;
        s_ov = out_valid;
        s_ol = out_last;
        s_re = out_data[0];
        s_im = out_data[1];
        acc  = v & in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                check("sb_re", 32'(s_re), 32'(exp_q[0].re));
                check("sb_im", 32'(s_im), 32'(exp_q[0].im));
                check("sb_last", 32'(s_ol), 32'(exp_q[0].last));
                if (rdy) begin
                    void'(exp_q.pop_front());
                    out_seen++;
                end
            end
        end else begin
            check("last_without_valid", 32'(out_last), 32'd0);
        end
        if (acc) begin
            fb_re[fb_n] = re;
            fb_im[fb_n] = im;
            fb_n++;
            if (fb_n == N) begin
                for (int k = 0; k < N; k++) begin
                    e.re   = fb_re[tb_bitrev(k, NL)];
                    e.im   = fb_im[tb_bitrev(k, NL)];
                    e.last = (k == N - 1);
                    exp_q.push_back(e);
                end
                fb_n = 0;
            end
        end
    endtask

    typedef struct {
        logic [15:0] in_re;
        logic [15:0] in_im;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
        logic        exp_last;
    } vec_t;

    function automatic logic [15:0] ext4_re(input int j);
        return (j % 2 == 1) ? 16'h7FFF : 16'h8000;
    endfunction
    function automatic logic [15:0] ext4_im(input int j);
        return (j < 8) ? 16'(32'h7FFF - j) : 16'(32'h8000 + j);
    endfunction
    function automatic logic [15:0] ext1_re(input int j);
        return (j % 2 == 1) ? 16'h8000 : 16'h7FFF;
    endfunction
    function automatic logic [15:0] ext1_im(input int j);
        return (j < 2) ? 16'h8000 : 16'h7FFF;
    endfunction

    initial begin
        vec_t vt[N];
        int   ord[N];
        logic acc, v, r;
        int   nacc, first_block, o0, nin, nout, k;

        ord = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < N; i++) begin
            vt[i].in_re    = 16'(i);
            vt[i].in_im    = 16'(100 + i);
            vt[i].exp_re   = 16'(ord[i]);
            vt[i].exp_im   = 16'(100 + ord[i]);
            vt[i].exp_last = (i == N - 1);
        end

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        a_iv = 1'b0; a_in = '0; a_or = 1'b0;
        b_iv = 1'b0; b_in = '0; b_or = 1'b0;
        fb_n = 0; out_seen = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);

        // single frame from the vector table
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, vt[i].in_re, vt[i].in_im, 1'b1, acc);
            check("sf_accept", 32'(acc), 32'd1);
            check("sf_no_early_valid", 32'(s_ov), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
            check(i == 0 ? "sf_latency_valid" : "sf_valid", 32'(s_ov), 32'd1);
            check("sf_re", 32'(s_re), 32'(vt[i].exp_re));
            check("sf_im", 32'(s_im), 32'(vt[i].exp_im));
            check("sf_last", 32'(s_ol), 32'(vt[i].exp_last));
        end

        // three back-to-back frames
        for (int c = 0; c < 32; c++) begin
            cycle(c < 24, 16'(1000 + c), 16'(2000 + c), 1'b1, acc);
            if (c < 24) check("stream_in_ready", 32'(s_ir), 32'd1);
            check("stream_out_valid", 32'(s_ov), 32'(c >= 8));
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // backpressure
        nacc = 0; first_block = -1;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 16'(3000 + nacc), 16'(16'hC000 + nacc), 1'b0, acc);
            if (!s_ir && first_block < 0) first_block = c;
            if (acc) nacc++;
        end
        check("bp_accepted", 32'(nacc), 32'd16);
        check("bp_first_block", 32'(first_block), 32'd16);
        check("bp_ready_low", 32'(s_ir), 32'd0);
        o0 = out_seen;
        for (int c = 0; c < 40 && out_seen - o0 < 16; c++)
            cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
        check("bp_drain_count", 32'(out_seen - o0), 32'd16);
        cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
        check("bp_ready_back", 32'(s_ir), 32'd1);

        // random valid/ready, 10 frames
        nin = 0; o0 = out_seen;
        for (int c = 0; c < 4000 && (nin < 80 || out_seen - o0 < 80); c++) begin
            v = (nin < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            cycle(v, 16'(nin * 3), 16'(32'hF000 + nin), r, acc);
            if (acc) nin++;
        end
        check("rnd_inputs", 32'(nin), 32'd80);
        check("rnd_outputs", 32'(out_seen - o0), 32'd80);
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset with frame 1 half drained and 5 samples of frame 2 written
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'(500 + i), 16'(600 + i), 1'b0, acc);
        for (int i = 8; i < 12; i++) cycle(1'b1, 16'(500 + i), 16'(600 + i), 1'b1, acc);
        cycle(1'b1, 16'(512), 16'(612), 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_last", 32'(out_last), 32'd0);
        exp_q.delete();
        fb_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        o0 = out_seen;
        for (int i = 0; i < N; i++) cycle(1'b1, 16'(i), 16'(100 + i), 1'b1, acc);
        for (int c = 0; c < 10; c++) cycle(1'b0, 16'd0, 16'd0, 1'b1, acc);
        check("rst_fresh_count", 32'(out_seen - o0), 32'd8);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // extreme values, N_LOG2=4
        nout = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b_iv = (c < 16);
            b_in[0] = ext4_re(c);
            b_in[1] = ext4_im(c);
            b_or = 1'b1;
            #1;
            if (b_iv) check("ext4_in_ready", 32'(b_ir), 32'd1);
            if (b_ov) begin
                k = (nout / 16) * 16 + tb_bitrev(nout % 16, 4);
                check("ext4_re", 32'(b_out[0]), 32'(ext4_re(k)));
                check("ext4_im", 32'(b_out[1]), 32'(ext4_im(k)));
                check("ext4_last", 32'(b_ol), 32'(nout % 16 == 15));
                nout++;
            end
        end
        b_iv = 1'b0;
        check("ext4_count", 32'(nout), 32'd16);

        // extreme values, N_LOG2=1, two frames
        nout = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a_iv = (c < 4);
            a_in[0] = ext1_re(c);
            a_in[1] = ext1_im(c);
            a_or = 1'b1;
            #1;
            if (a_iv) check("ext1_in_ready", 32'(a_ir), 32'd1);
            if (a_ov) begin
                k = (nout / 2) * 2 + tb_bitrev(nout % 2, 1);
                check("ext1_re", 32'(a_out[0]), 32'(ext1_re(k)));
                check("ext1_im", 32'(a_out[1]), 32'(ext1_im(k)));
                check("ext1_last", 32'(a_ol), 32'(nout % 2 == 1));
                nout++;
            end
        end
        a_iv = 1'b0;
        check("ext1_count", 32'(nout), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buf.md
Name: fft_bitrev_buf

Overview:
- Ping-pong reorder buffer directly downstream of the last radix-2 FFT butterfly stage.
- Accepts one complex sample per handshake in the stage's bit-reversed output order.
- Emits each N-point frame in natural order, with a frame-end marker.
- Two banks, so one frame can be written while the previous frame drains. This gives full throughput when both sides stream continuously.

Parameters:
- DATA_WIDTH, 16, bits per real/imaginary component. Same format as butterfly data.
- N_LOG2, 4, log2 of frame length N. Legal range 1..10.

Ports:
- clk_i, input, 1, single clock; all state is updated on its rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- in_data_i, input, [1:0][DATA_WIDTH-1:0] signed, complex sample; [0] = re, [1] = im.
- in_valid_i, input, 1, in_data_i is valid.
- in_ready_o, output, 1, buffer can accept a sample this cycle.
- out_data_o, output, [1:0][DATA_WIDTH-1:0] signed, reordered complex sample.
- out_valid_o, output, 1, out_data_o is valid.
- out_ready_i, input, 1, consumer accepts out_data_o.
- out_last_o, output, 1, out_data_o is sample N-1 of the frame.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - wr_cnt=0, rd_cnt=0, wr_sel=0, rd_sel=0, full[1:0]=0.
  - in_ready_o=1 on the first cycle after deassertion; out_valid_o=0, out_last_o=0.
  - Memory contents are not reset; they are don't-care.
- A reset asserted mid-frame discards all partial and complete frames, with no outputs afterwards.
- Handshake rules:
  - Transfer occurs when valid & ready are both 1 on a rising edge.
  - Valid must not depend combinationally on ready.
  - out_data_o and out_last_o are held stable while out_valid_o=1 and out_ready_i=0.
- Write side:
  - in_ready_o = ~full[wr_sel].
  - On input transfer: mem[wr_sel][bitrev(wr_cnt)] <= in_data_i; wr_cnt <= wr_cnt+1, wrapping modulo N.
  - When wr_cnt==N-1 transfers: full[wr_sel] <= 1 and wr_sel toggles.
- Read side:
  - out_valid_o = full[rd_sel].
  - out_data_o = mem[rd_sel][rd_cnt] (combinational array read; registered-output variant not permitted).
  - out_last_o = out_valid_o & (rd_cnt==N-1).
  - On output transfer: rd_cnt <= rd_cnt+1, wrapping modulo N.
  - On the transfer with rd_cnt==N-1: full[rd_sel] <= 0 and rd_sel toggles.
- Per-bank state:
  - FILLING (full=0, wr_sel points at it) -> FULL on the last write.
  - FULL -> DRAINING while rd_sel points at it; DRAINING is encoded by the full bit plus rd_sel.
  - DRAINING -> EMPTY on the last read.
- Latency: with out_ready_i=1, the first natural-order sample is valid on the cycle after the input transfer of sample N-1.
- Simultaneous events:
  - Last-write and last-read in the same cycle on different banks: both flag updates apply.
  - A bank freed by the last read becomes writable only on the next cycle, because in_ready_o comes from the registered flag. There is no combinational ready bypass.
- Both banks full: in_ready_o=0 until the drain of rd_sel completes. Input stalls without losing data.
- in_valid_i high while in_ready_o=0: no write, and wr_cnt is unchanged.
- Width rules: no arithmetic on data (pass-through); counters are N_LOG2 bits wide; bitrev reverses all N_LOG2 bits.

Decomposition:
- Package fft_pkg:
  - typedef cplx_t (packed [1:0][DATA_WIDTH-1:0] signed, for the default width).
  - function bitrev(idx, nbits).
  - localparam defaults DATA_WIDTH=16, FRAC_BITS=15.
- Sub-module fft_pingpong_ctrl: owns wr_cnt, rd_cnt, wr_sel, rd_sel, full[1:0], ready/valid/last generation, and write/read addresses.
- The top module holds the 2×N memory array and the data muxing.

Test Plan (N_LOG2=3, DATA_WIDTH=16 unless noted):
- Single frame, out_ready_i=1: inputs re=0..7, im=100..107 in order -> outputs re 0,4,2,6,1,5,3,7 (im +100). out_last_o only on re=7. First out_valid_o is 1 cycle after input 7.
- Continuous streaming, 3 back-to-back frames with in_valid_i=out_ready_i=1 -> in_ready_o never drops after the first frame. Each frame is reordered correctly, with one output per cycle.
- Backpressure, out_ready_i=0 for 20 cycles while 16 inputs are offered -> in_ready_o=0 after exactly 16 accepted inputs. out_data_o stays stable. On release, 16 outputs arrive in correct order.
- Random valid/ready toggling (50% each) for 10 frames, scoreboarded against the bitrev model -> no lost or duplicated samples; every 8th output has out_last_o=1.
- Reset mid-frame: assert rst_i after 5 inputs of frame 2, with frame 1 half-drained -> out_valid_o=0 immediately (asynchronous). After release, in_ready_o=1 and a fresh frame 0..7 reorders correctly.
- Extreme values, with N_LOG2=1 and N_LOG2=4: inputs 0x8000/0x7FFF -> outputs are bit-exact pass-through in bit-reversed order.
